// File: rtl/bus_arbiter2_if.sv
// Bus bundle between the two masters, the arbiter and the shared slave.
//   master 0 (UART) : i_m0_cs/we/addr/dat in, o_m0_dat/ack out
//   master 1 (CPU)  : i_m1_cs/we/addr/dat in, o_m1_dat/ack out
//   slave           : o_s_cs/we/addr/dat out, i_s_dat/ack in
// Signal names are written from the arbiter's point of view.
// modport slave  : the arbiter itself (serves both masters).
// modport master : the surrounding masters and slave model that drive it.
interface bus_arbiter2_if;
    logic        i_m0_cs;
    logic        i_m0_we;
    logic [15:0] i_m0_addr;
    logic [15:0] i_m0_dat;
    logic [15:0] o_m0_dat;
    logic        o_m0_ack;

    logic        i_m1_cs;
    logic        i_m1_we;
    logic [15:0] i_m1_addr;
    logic [15:0] i_m1_dat;
    logic [15:0] o_m1_dat;
    logic        o_m1_ack;

    logic        o_s_cs;
    logic        o_s_we;
    logic [15:0] o_s_addr;
    logic [15:0] o_s_dat;
    logic [15:0] i_s_dat;
    logic        i_s_ack;

    modport slave (
        input  i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
        output o_m0_dat, o_m0_ack,
        input  i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
        output o_m1_dat, o_m1_ack,
        output o_s_cs, o_s_we, o_s_addr, o_s_dat,
        input  i_s_dat, i_s_ack
    );

    modport master (
        output i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
        input  o_m0_dat, o_m0_ack,
        output i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
        input  o_m1_dat, o_m1_ack,
        input  o_s_cs, o_s_we, o_s_addr, o_s_dat,
        output i_s_dat, i_s_ack
    );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-master / one-slave round-robin arbiter for the 16-bit memory bus.
// Master 0 is the UART debug port, master 1 the CPU data port. A grant is
// held until the slave acks; a timeout counter forces an ack with
// TIMEOUT_DATA so a hung slave cannot lock the bus (TIMEOUT=0 disables it).
// Ports:
//   i_clk      system clock (posedge)
//   i_reset    synchronous active-high reset
//   bus        bus_arbiter2_if.slave : both master ports plus slave port
//   i_err_clr  clears the sticky timeout flag
//   o_timeout  one-cycle pulse on a forced ack
//   o_err      sticky timeout flag
module bus_arbiter2 #(
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
    input  logic              i_clk,
    input  logic              i_reset,
    bus_arbiter2_if.slave     bus,
    input  logic              i_err_clr,
    output logic              o_timeout,
    output logic              o_err
);

    localparam int unsigned    CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;      // last granted master
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Signals of whichever master currently holds the grant.
    logic          g1;
    logic          g_cs;
    logic          g_we;
    logic [15:0]   g_addr;
    logic [15:0]   g_dat;
    logic          ack;
    logic          forced;

    assign g1     = (state_q == GRANT1);
    assign g_cs   = g1 ? bus.i_m1_cs   : bus.i_m0_cs;
    assign g_we   = g1 ? bus.i_m1_we   : bus.i_m0_we;
    assign g_addr = g1 ? bus.i_m1_addr : bus.i_m0_addr;
    assign g_dat  = g1 ? bus.i_m1_dat  : bus.i_m0_dat;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;            // master 0 wins the first tie
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        err_d        = err_q & ~i_err_clr;   // a timeout below overrides the clear
        ack          = 1'b0;
        forced       = 1'b0;
        o_timeout    = 1'b0;
        bus.o_s_cs   = 1'b0;
        bus.o_s_we   = 1'b0;
        bus.o_s_addr = '0;
        bus.o_s_dat  = '0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.i_m0_cs && (!bus.i_m1_cs || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (bus.i_m1_cs) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                bus.o_s_cs   = g_cs;
                bus.o_s_we   = g_we;
                bus.o_s_addr = g_addr;
                bus.o_s_dat  = g_dat;
                if (!g_cs) begin
                    // abort: master withdrew before the slave answered
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.i_s_ack) begin
                    ack     = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LIMIT)) begin
                    ack        = 1'b1;
                    forced     = 1'b1;
                    bus.o_s_cs = 1'b0;
                    o_timeout  = 1'b1;
                    err_d      = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_m0_ack = ack & ~g1;
    assign bus.o_m1_ack = ack & g1;
    assign bus.o_m0_dat = (forced && !g1) ? TIMEOUT_DATA : bus.i_s_dat;
    assign bus.o_m1_dat = (forced && g1)  ? TIMEOUT_DATA : bus.i_s_dat;
    assign o_err        = err_q;

endmodule
